// File: rtl/scan_mux2_drv.sv
// Two-digit scan driver for the 7-segment decoder stage.
// Time-multiplexes two hex digits onto num and drives the matching
// active-low digit enables. A one-deep ready/valid buffer holds a new
// value until the next frame boundary, so one frame never mixes old and
// new digits. Includes per-digit blanking, leading-zero suppression on
// the high digit and optional dark gap states between digits.
//
// state   | meaning
// --------+-------------------------------------------------
// S_D0    | digit 0 (low nibble) driven for DIV clocks
// S_GAP0  | both digits dark for GAP clocks
// S_D1    | digit 1 (high nibble) driven for DIV clocks
// S_GAP1  | both digits dark for GAP clocks; reset state
module scan_mux2_drv #(
    parameter int DIV   = 50000,
    parameter int GAP   = 2,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    input  logic [1:0] blank_mask,
    input  logic       lz_sup,
    output logic [3:0] num,
    output logic [1:0] scan_select,
    output logic       frame_tick
);

    typedef enum logic [1:0] {S_D0, S_GAP0, S_D1, S_GAP1} state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    // With no gap states the only gap dwell is the one after reset, which
    // stands in for a digit-1 slot so the first boundary comes DIV clocks in.
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP > 0) ? CNT_W'(GAP - 1) : CNT_W'(DIV - 1);

    state_t           state_q, state_d, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d, dwell_last;
    logic [7:0]       disp_q, disp_d;
    logic [7:0]       pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             load_ready_q;
    logic [3:0]       num_q;
    logic [1:0]       sel_q;
    logic             tick_q;
    logic             advance, boundary, accept;

    // Dwell timing, sequencing and the load/transfer bookkeeping.
    always_comb begin
        dwell_last  = (state_q == S_D0 || state_q == S_D1) ? DIV_LAST : GAP_LAST;
        advance     = (cnt_q == dwell_last);
        state_nxt   = state_q;
        case (state_q)
            S_D0:    state_nxt = (GAP > 0) ? S_GAP0 : S_D1;
            S_GAP0:  state_nxt = S_D1;
            S_D1:    state_nxt = (GAP > 0) ? S_GAP1 : S_D0;
            default: state_nxt = S_D0;
        endcase
        state_d     = advance ? state_nxt : state_q;
        cnt_d       = advance ? '0 : cnt_q + 1'b1;
        boundary    = advance && (state_nxt == S_D0);
        accept      = load_valid && load_ready_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        // Transfer and accept are exclusive: accept needs an empty buffer.
        if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end
    end

    // State, counter, buffers and registered outputs, all on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_GAP1;
            cnt_q        <= '0;
            disp_q       <= 8'h00;
            pend_q       <= 8'h00;
            pend_full_q  <= 1'b0;
            load_ready_q <= 1'b1;
            num_q        <= 4'h0;
            sel_q        <= 2'b11;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            load_ready_q <= ~pend_full_d;
            tick_q       <= boundary;
            // Blanking controls are sampled on entry and held for the dwell.
            if (advance) begin
                case (state_nxt)
                    S_D0: begin
                        num_q <= disp_d[3:0];
                        sel_q <= blank_mask[0] ? 2'b11 : 2'b10;
                    end
                    S_D1: begin
                        num_q <= disp_d[7:4];
                        sel_q <= (blank_mask[1] || (lz_sup && disp_d[7:4] == 4'h0)) ? 2'b11 : 2'b01;
                    end
                    default: sel_q <= 2'b11;
                endcase
            end
        end
    end

    assign load_ready  = load_ready_q;
    assign num         = num_q;
    assign scan_select = sel_q;
    assign frame_tick  = tick_q;

endmodule

// File: tb/tb_scan_mux2_drv.sv
module tb_scan_mux2_drv;

    localparam int DIV = 4;
    localparam int GAP = 1;
    localparam int F   = 2 * (DIV + GAP);

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst2;
    logic       vld;
    logic [7:0] data;
    logic [1:0] blank;
    logic       lz;
    logic       ready_a, tick_a, ready_b, tick_b;
    logic [3:0] num_a, num_b;
    logic [1:0] sel_a, sel_b;

    scan_mux2_drv #(.DIV(DIV), .GAP(GAP), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .load_valid(vld), .load_ready(ready_a),
        .load_data(data), .blank_mask(blank), .lz_sup(lz),
        .num(num_a), .scan_select(sel_a), .frame_tick(tick_a)
    );

    scan_mux2_drv #(.DIV(3), .GAP(0), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst(rst2), .load_valid(1'b0), .load_ready(ready_b),
        .load_data(8'h00), .blank_mask(2'b00), .lz_sup(1'b0),
        .num(num_b), .scan_select(sel_b), .frame_tick(tick_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0] num;
        logic [1:0] sel;
        logic       tick;
        logic       ready;
    } exp_t;

    exp_t sb_q[$];

    // Reference model tracks the position within a frame:
    // 0..DIV-1 digit 0, DIV..DIV+GAP-1 gap, then digit 1, then gap.
    int         m_pos;
    logic [7:0] m_disp, m_pend;
    logic       m_pfull, m_ready, m_tick, m_acc;
    logic [3:0] m_num;
    logic [1:0] m_sel;

    task automatic model_reset();
        m_pos   = F - GAP;
        m_disp  = 8'h00;
        m_pend  = 8'h00;
        m_pfull = 1'b0;
        m_ready = 1'b1;
        m_num   = 4'h0;
        m_sel   = 2'b11;
        m_tick  = 1'b0;
        m_acc   = 1'b0;
    endtask

    task automatic step();
        int   npos;
        exp_t e;
        m_acc  = vld && m_ready;
        npos   = (m_pos + 1) % F;
        m_tick = (npos == 0);
        if (npos == 0) begin
            if (m_pfull) begin
                m_disp  = m_pend;
                m_pfull = 1'b0;
            end
            m_num = m_disp[3:0];
            m_sel = blank[0] ? 2'b11 : 2'b10;
        end else if (npos == DIV + GAP) begin
            m_num = m_disp[7:4];
            m_sel = (blank[1] || (lz && m_disp[7:4] == 4'h0)) ? 2'b11 : 2'b01;
        end else if (npos == DIV || npos == F - GAP) begin
            m_sel = 2'b11;
        end
        if (m_acc) begin
            m_pend  = data;
            m_pfull = 1'b1;
        end
        m_ready = !m_pfull;
        m_pos   = npos;
        e.num = m_num; e.sel = m_sel; e.tick = m_tick; e.ready = m_ready;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("scan_select", 8'(sel_a), 8'(e.sel));
        chk("num", 8'(num_a), 8'(e.num));
        chk("frame_tick", 8'(tick_a), 8'(e.tick));
        chk("load_ready", 8'(ready_a), 8'(e.ready));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < F && m_pos != p; i++) step();
    endtask

    initial begin
        int got;
        rst = 1'b1; rst2 = 1'b1;
        vld = 1'b0; data = 8'h00; blank = 2'b00; lz = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", 8'(sel_a), 8'h03);
        chk("rst_num", 8'(num_a), 8'h00);
        chk("rst_tick", 8'(tick_a), 8'h00);
        chk("rst_ready", 8'(ready_a), 8'h01);
        chk("rst_b_sel", 8'(sel_b), 8'h03);
        rst = 1'b0;

        // Idle frames after reset.
        run(2 * F);

        // Load mid digit 1.
        wait_pos(DIV + GAP + 1);
        vld = 1'b1; data = 8'h3A;
        step();
        vld = 1'b0; data = 8'hFF;
        run(2 * F + 3);

        // Back-to-back loads with valid held.
        vld = 1'b1; data = 8'h12;
        step();
        data = 8'h34;
        got = 0;
        for (int i = 0; i < 2 * F && got == 0; i++) begin
            step();
            if (m_acc) got = 1;
        end
        chk("b2b_accept", 8'(got), 8'h01);
        vld = 1'b0;
        run(3 * F);

        // Leading-zero suppression and blanking.
        vld = 1'b1; data = 8'h05;
        step();
        vld = 1'b0; lz = 1'b1;
        run(2 * F + 2);
        lz = 1'b0;
        run(F + 1);
        blank = 2'b01;
        run(F + 1);
        blank = 2'b10;
        run(F + 1);
        blank = 2'b00;

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            vld   = ($urandom_range(0, 3) == 0);
            data  = 8'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            lz    = 1'($urandom);
            step();
        end
        vld = 1'b0; blank = 2'b00; lz = 1'b0;

        // Asynchronous reset mid digit 1 with a value pending.
        run(F);
        wait_pos(DIV + GAP + 2);
        vld = 1'b1; data = 8'hC9;
        step();
        vld = 1'b0;
        run(2 * F);
        wait_pos(DIV + GAP + 1);
        vld = 1'b1; data = 8'h77;
        step();
        vld = 1'b0;
        step();
        chk("pre_rst_num", 8'(num_a), 8'h0C);
        #3 rst = 1'b1;
        #1;
        chk("async_sel", 8'(sel_a), 8'h03);
        chk("async_num", 8'(num_a), 8'h00);
        chk("async_ready", 8'(ready_a), 8'h01);
        chk("async_tick", 8'(tick_a), 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        sb_q.delete();
        run(3 * F);

        // GAP=0 instance: dark reset dwell of DIV clocks, then 10/01 alternation.
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            logic [1:0] es;
            logic       et;
            @(posedge clk);
            #1;
            if (k < 3) begin
                es = 2'b11;
                et = 1'b0;
            end else begin
                es = (((k - 3) % 6) < 3) ? 2'b10 : 2'b01;
                et = (((k - 3) % 6) == 0);
            end
            chk("g0_sel", 8'(sel_b), 8'(es));
            chk("g0_tick", 8'(tick_b), 8'(et));
            chk("g0_num", 8'(num_b), 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
